// File: rtl/imul_retire_pkg.sv
// Shared constants and entry types for the multiplier retire block.
// Field widths here define both the tracker stages and the writeback FIFO entries.
package imul_retire_pkg;

  localparam int IMUL_RET_DEPTH = 4;
  localparam int IMUL_RET_LAT   = 3;
  localparam int TAG_W          = 9;
  localparam int II_W           = 10;
  localparam int RES_W          = 65;
  localparam int FLG_W          = 6;
  localparam int OCC_W          = 3;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [II_W-1:0]  ii;
    logic             fwr;
  } stage_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [II_W-1:0]  ii;
    logic [RES_W-1:0] res;
    logic [FLG_W-1:0] flg;
    logic             fwr;
  } wb_entry_t;

  // Ops that do not write flags retire with an all-zero flag field.
  function automatic logic [FLG_W-1:0] mask_flg(input logic fwr, input logic [FLG_W-1:0] flg);
    return fwr ? flg : {FLG_W{1'b0}};
  endfunction

endpackage

// File: rtl/imul_retire_if.sv
// Issue, multiplier-result and writeback signals of the retire block.
// master = scheduler/multiplier/writeback side, slave = imul_retire.
interface imul_retire_if;
  import imul_retire_pkg::*;

  logic             clkEn;
  logic             issue_en;
  logic [TAG_W-1:0] issue_tag;
  logic [II_W-1:0]  issue_ii;
  logic             issue_fwr;
  logic [RES_W-1:0] mul_res;
  logic [FLG_W-1:0] mul_flg;
  logic             flush;
  logic             wb_rdy;
  logic             stall;
  logic             wb_vld;
  logic [TAG_W-1:0] wb_tag;
  logic [II_W-1:0]  wb_ii;
  logic [RES_W-1:0] wb_res;
  logic [FLG_W-1:0] wb_flg;
  logic             wb_fwr;
  logic [OCC_W-1:0] occ;

  modport master (
    output clkEn, issue_en, issue_tag, issue_ii, issue_fwr, mul_res, mul_flg, flush, wb_rdy,
    input  stall, wb_vld, wb_tag, wb_ii, wb_res, wb_flg, wb_fwr, occ
  );

  modport slave (
    input  clkEn, issue_en, issue_tag, issue_ii, issue_fwr, mul_res, mul_flg, flush, wb_rdy,
    output stall, wb_vld, wb_tag, wb_ii, wb_res, wb_flg, wb_fwr, occ
  );

endinterface

// File: rtl/imul_ret_fifo.sv
// Writeback FIFO with wrap-around pointers; head entry is read combinationally.
// Flush wins over push/pop; storage is reset so the head reads zero out of reset.
module imul_ret_fifo
  import imul_retire_pkg::*;
#(
  parameter int  DEPTH = IMUL_RET_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  wb_entry_t        push_data,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pop_s;
  logic             full_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign pop_s  = pop && (cnt_r != {CNT_W{1'b0}});
  assign full_s = (cnt_r == CNT_W'(DEPTH));

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      if (push && !pop_s)      cnt_r <= cnt_r + CNT_W'(1);
      else if (!push && pop_s) cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = cnt_r;

  imul_ret_fifo_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .full (full_s)
  );

endmodule

// File: rtl/imul_ret_fifo_chk.sv
// Simulation checker for the writeback FIFO: a push must never land on a full FIFO.
module imul_ret_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/imul_retire.sv
// Tracks multiplier ops through the clkEn-gated pipeline and buffers finished
// results for writeback; stall keeps total occupancy below the FIFO depth.
module imul_retire
  import imul_retire_pkg::*;
#(
  parameter int  DEPTH = IMUL_RET_DEPTH,
  parameter int  LAT   = IMUL_RET_LAT,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst,
  imul_retire_if.slave bus
);

  stage_t           stage_r [LAT];
  logic [RES_W-1:0] res_r;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             stall_s;
  logic [OCC_W-1:0] occ_s;
  logic [CNT_W-1:0] fifo_cnt_s;
  wb_entry_t        push_data_s;
  wb_entry_t        head_s;

  // Occupancy, stall and the accept/push/pop strobes; flush suppresses all three.
  always_comb begin
    occ_s = OCC_W'(fifo_cnt_s);
    for (int i = 0; i < LAT; i++) occ_s = occ_s + OCC_W'(stage_r[i].vld);
    stall_s  = (occ_s >= OCC_W'(DEPTH - 1));
    accept_s = bus.issue_en && !stall_s && bus.clkEn && !bus.flush;
    push_s   = stage_r[LAT-1].vld && bus.clkEn && !bus.flush;
    pop_s    = (fifo_cnt_s != {CNT_W{1'b0}}) && bus.wb_rdy && !bus.flush;
    push_data_s = '{tag: stage_r[LAT-1].tag,
                    ii:  stage_r[LAT-1].ii,
                    res: res_r,
                    flg: mask_flg(stage_r[LAT-1].fwr, bus.mul_flg),
                    fwr: stage_r[LAT-1].fwr};
  end

  // Tracker shift pipeline; the result is captured as the op moves into the last stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) stage_r[i] <= '0;
      res_r <= {RES_W{1'b0}};
    end else if (bus.flush) begin
      for (int i = 0; i < LAT; i++) stage_r[i].vld <= 1'b0;
    end else if (bus.clkEn) begin
      stage_r[0] <= '{vld: accept_s, tag: bus.issue_tag, ii: bus.issue_ii, fwr: bus.issue_fwr};
      for (int i = 1; i < LAT; i++) stage_r[i] <= stage_r[i-1];
      if (stage_r[LAT-2].vld) res_r <= bus.mul_res;
    end
  end

  imul_ret_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_cnt_s)
  );

  assign bus.stall  = stall_s;
  assign bus.occ    = occ_s;
  assign bus.wb_vld = (fifo_cnt_s != {CNT_W{1'b0}});
  assign bus.wb_tag = head_s.tag;
  assign bus.wb_ii  = head_s.ii;
  assign bus.wb_res = head_s.res;
  assign bus.wb_flg = head_s.flg;
  assign bus.wb_fwr = head_s.fwr;

endmodule

// File: tb/tb_imul_retire.sv
// Directed bench for imul_retire: single op, clkEn gaps, backpressure,
// wrap-around ordering, flush and asynchronous reset.
module tb_imul_retire;
  import imul_retire_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  imul_retire_if bus ();

  imul_retire #(.DEPTH(4), .LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_issue(input logic en, input logic [8:0] t, input logic [9:0] i, input logic f);
    bus.issue_en  = en;
    bus.issue_tag = t;
    bus.issue_ii  = i;
    bus.issue_fwr = f;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ii[$];
    int n;
    int k;

    rst = 1'b0;
    bus.clkEn = 1'b1;
    bus.flush = 1'b0;
    bus.wb_rdy = 1'b0;
    bus.mul_res = 65'h0;
    bus.mul_flg = 6'h0;
    set_issue(1'b0, 9'd0, 10'd0, 1'b0);
    tick();
    tick();
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_wb_vld", bus.wb_vld, 1'b0);
    chk("rst_occ", bus.occ, 3'd0);
    chk("rst_wb_tag", bus.wb_tag, 9'd0);
    chk("rst_wb_res", bus.wb_res, 65'h0);
    rst = 1'b1;

    // single op, issued on the first edge after reset release
    set_issue(1'b1, 9'd5, 10'd17, 1'b1);
    tick();
    chk("t1_occ_after_issue", bus.occ, 3'd1);
    set_issue(1'b0, 9'd0, 10'd0, 1'b0);
    tick();
    bus.mul_res = 65'h1234;
    tick();
    bus.mul_res = 65'h0;
    bus.mul_flg = 6'b000101;
    chk("t1_vld_early", bus.wb_vld, 1'b0);
    tick();
    bus.mul_flg = 6'h0;
    chk("t1_vld", bus.wb_vld, 1'b1);
    chk("t1_tag", bus.wb_tag, 9'd5);
    chk("t1_ii", bus.wb_ii, 10'd17);
    chk("t1_res", bus.wb_res, 65'h1234);
    chk("t1_flg", bus.wb_flg, 6'b000101);
    chk("t1_fwr", bus.wb_fwr, 1'b1);
    bus.wb_rdy = 1'b1;
    tick();
    bus.wb_rdy = 1'b0;
    chk("t1_popped", bus.wb_vld, 1'b0);
    chk("t1_occ0", bus.occ, 3'd0);

    // clkEn gap of two cycles after issue
    set_issue(1'b1, 9'd6, 10'd33, 1'b0);
    tick();
    set_issue(1'b0, 9'd0, 10'd0, 1'b0);
    bus.clkEn = 1'b0;
    tick();
    tick();
    chk("t2_occ_hold", bus.occ, 3'd1);
    bus.clkEn = 1'b1;
    tick();
    bus.mul_res = 65'h1_0000_0000_0000_abcd;
    tick();
    bus.mul_res = 65'h0;
    bus.mul_flg = 6'h3f;
    chk("t2_vld_t0p4", bus.wb_vld, 1'b0);
    tick();
    bus.mul_flg = 6'h0;
    chk("t2_vld_t0p5", bus.wb_vld, 1'b1);
    chk("t2_res", bus.wb_res, 65'h1_0000_0000_0000_abcd);
    chk("t2_flg_masked", bus.wb_flg, 6'h0);
    bus.wb_rdy = 1'b1;
    tick();
    bus.wb_rdy = 1'b0;

    // backpressure: three ops fill occupancy, fourth issue ignored
    set_issue(1'b1, 9'd1, 10'd101, 1'b0);
    tick();
    set_issue(1'b1, 9'd2, 10'd102, 1'b0);
    tick();
    chk("t3_stall_at2", bus.stall, 1'b0);
    set_issue(1'b1, 9'd3, 10'd103, 1'b0);
    tick();
    chk("t3_occ3", bus.occ, 3'd3);
    chk("t3_stall", bus.stall, 1'b1);
    set_issue(1'b1, 9'd4, 10'd104, 1'b0);
    tick();
    set_issue(1'b0, 9'd0, 10'd0, 1'b0);
    chk("t3_occ_after_4th", bus.occ, 3'd3);
    tick();
    tick();
    chk("t3_head1", bus.wb_tag, 9'd1);
    bus.wb_rdy = 1'b1;
    tick();
    chk("t3_stall_drop", bus.stall, 1'b0);
    chk("t3_occ2", bus.occ, 3'd2);
    chk("t3_head2", bus.wb_tag, 9'd2);
    tick();
    chk("t3_head3", bus.wb_ii, 10'd103);
    tick();
    chk("t3_empty", bus.wb_vld, 1'b0);
    tick();
    chk("t3_no_4th", bus.occ, 3'd0);
    bus.wb_rdy = 1'b0;

    // ten ops through the wrapping FIFO with wb_rdy toggling
    n = 0;
    k = 0;
    for (int c = 0; c < 45; c++) begin
      set_issue(1'b0, 9'd0, 10'd0, 1'b0);
      if ((c % 3 == 0) && (n < 10)) begin
        chk("t4_no_stall", bus.stall, 1'b0);
        set_issue(1'b1, 9'(n), 10'(200 + n), 1'b1);
        exp_ii.push_back(200 + n);
        n++;
      end
      bus.wb_rdy = (c % 2 == 1);
      if (bus.wb_vld && bus.wb_rdy) begin
        chk("t4_order_ii", bus.wb_ii, 10'(exp_ii[k]));
        k++;
      end
      tick();
    end
    bus.wb_rdy = 1'b0;
    chk("t4_count", 32'(k), 32'd10);
    chk("t4_drained", bus.occ, 3'd0);

    // flush with two in flight, one buffered, and a simultaneous issue
    set_issue(1'b1, 9'd10, 10'd400, 1'b0);
    tick();
    set_issue(1'b1, 9'd11, 10'd401, 1'b0);
    tick();
    set_issue(1'b1, 9'd12, 10'd402, 1'b0);
    tick();
    set_issue(1'b0, 9'd0, 10'd0, 1'b0);
    tick();
    chk("t5_pre_occ", bus.occ, 3'd3);
    chk("t5_pre_vld", bus.wb_vld, 1'b1);
    bus.flush = 1'b1;
    set_issue(1'b1, 9'd13, 10'd403, 1'b0);
    tick();
    bus.flush = 1'b0;
    set_issue(1'b0, 9'd0, 10'd0, 1'b0);
    chk("t5_occ0", bus.occ, 3'd0);
    chk("t5_vld0", bus.wb_vld, 1'b0);
    chk("t5_stall0", bus.stall, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_no_late_push", bus.wb_vld, 1'b0);
    end

    // asynchronous reset mid-drain, then a normal op with fwr=0
    set_issue(1'b1, 9'd20, 10'd300, 1'b1);
    tick();
    set_issue(1'b1, 9'd21, 10'd301, 1'b1);
    tick();
    set_issue(1'b0, 9'd0, 10'd0, 1'b0);
    tick();
    tick();
    tick();
    bus.wb_rdy = 1'b1;
    tick();
    chk("t6_mid_drain", bus.wb_ii, 10'd301);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_vld", bus.wb_vld, 1'b0);
    chk("t6_async_stall", bus.stall, 1'b0);
    chk("t6_async_occ", bus.occ, 3'd0);
    chk("t6_async_ii", bus.wb_ii, 10'd0);
    bus.wb_rdy = 1'b0;
    tick();
    rst = 1'b1;
    set_issue(1'b1, 9'd9, 10'd500, 1'b0);
    tick();
    set_issue(1'b0, 9'd0, 10'd0, 1'b0);
    chk("t6_first_issue", bus.occ, 3'd1);
    tick();
    bus.mul_res = 65'h55;
    tick();
    bus.mul_res = 65'h0;
    bus.mul_flg = 6'h2a;
    tick();
    bus.mul_flg = 6'h0;
    chk("t6_vld", bus.wb_vld, 1'b1);
    chk("t6_tag", bus.wb_tag, 9'd9);
    chk("t6_ii", bus.wb_ii, 10'd500);
    chk("t6_res", bus.wb_res, 65'h55);
    chk("t6_flg", bus.wb_flg, 6'h0);
    chk("t6_fwr", bus.wb_fwr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
